fft_input_loader: RTL and testbench
===================================

Name: fft_input_loader

Overview:
- Write-side front end of the pipelined FFT. Accepts a serial complex sample stream through a valid/ready handshake and writes each N-sample frame into one bank of a ping-pong stage-0 RAM.
- Hands each completed bank to the first stage read controller with a start pulse. Takes the bank back when that controller's done pulse arrives.
- Lets input streaming overlap with FFT reading of the other bank.

Parameters:
- bit_width, 29, width of each real/imag sample component.
- N, 16, samples per frame (power of two).
- SIZE, 4, log2(N); address width.
- BITREV, 0, 1 = write address is bit-reversed sample index; 0 = natural order.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input sample valid.
- s_ready  output  1  loader can accept a sample this cycle.
- s_re  input  bit_width  sample real part.
- s_im  input  bit_width  sample imaginary part.
- s_last  input  1  marks the final sample of a frame.
- en_wr  output  1  RAM write strobe.
- wr_bank  output  1  bank being written.
- wr_ptr  output  SIZE  RAM write address.
- wr_re  output  bit_width  write data, real part.
- wr_im  output  bit_width  write data, imaginary part.
- start_o  output  1  one-cycle pulse: bank start_bank is full and handed to the reader.
- start_bank  output  1  bank handed over; held until the next start_o.
- done_i  input  1  one-cycle pulse from the reader: the busy bank is released.
- err_frame  output  1  one-cycle pulse on a frame-length mismatch.
- busy_o  output  1  a bank is currently owned by the reader.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs are 0 and both banks are FREE. Fill bank = 0, sample index = 0, start_bank = 0.
- Bank states: FREE, FILLING, FULL, BUSY, kept as a 2-bit state per bank.
- Handshake: a sample is accepted when s_valid && s_ready.
  - s_ready = 1 while the fill bank is FREE or FILLING.
  - s_ready is registered, so it deasserts the cycle after the last sample of a frame is accepted.
- Write:
  - The write issues on the cycle after acceptance (latency 1).
  - en_wr = 1; wr_bank = fill bank; wr_re/wr_im = captured data.
  - wr_ptr = index, or bit-reverse(index) when BITREV = 1.
  - The first accepted sample moves the bank FREE->FILLING. Index increments per accepted sample.
- Frame close: closes on an accepted sample with index == N-1, or with s_last = 1, whichever comes first.
  - Index resets to 0; the bank becomes FULL; the fill bank toggles.
  - err_frame pulses if s_last = 1 with index != N-1 (short frame; locations not written keep stale data), or if index == N-1 with s_last = 0.
- Start:
  - When a bank is FULL and no bank is BUSY, start_o pulses for 1 cycle, start_bank = that bank, and the bank becomes BUSY.
  - If both banks are FULL, the older one is started first.
  - Earliest start_o is 1 cycle after the frame-close cycle, which is the same cycle as the last en_wr.
- Release: done_i moves the BUSY bank to FREE. done_i with no bank BUSY is ignored.
- Simultaneous done_i and a FULL bank waiting: the release and the new start_o occur in the same cycle (the released bank is FREE, the other becomes BUSY).
- Simultaneous done_i and a frame close into the other bank: the close completes; start_o for that bank follows 1 cycle later.
- Back-pressure: if the next fill bank is FULL or BUSY, s_ready stays 0 until it is released by done_i and returns to FREE. s_ready rises the cycle after release.
- busy_o = 1 whenever either bank is BUSY.
- Reset mid-frame: partial data is discarded and the state machine returns to the reset state. No start_o is issued for the partial frame.
- Index and wr_ptr wrap modulo N.

Test Plan:
- Single frame, N = 16, BITREV = 0: 16 back-to-back samples with value = index and s_last on the 16th.
  - Expect en_wr at ptr 0..15 into bank 0, each 1 cycle after acceptance.
  - Expect start_o with start_bank = 0 on the same cycle as the ptr-15 write; no err_frame.
- BITREV = 1, same stimulus: sample 1 -> ptr 8, sample 3 -> ptr 12, sample 14 -> ptr 7.
- Three back-to-back frames with done_i withheld:
  - Frame 2 fills bank 1; s_ready drops after its 16th sample.
  - done_i -> bank 1 start_o in the same cycle; s_ready = 1 the following cycle; frame 3 goes to bank 0.
- Short frame: s_last on the 10th sample.
  - Expect err_frame pulse, bank FULL, start_o; the next frame starts at ptr 0 in bank 1.
- Missing s_last on the 16th sample: the frame closes anyway, err_frame pulses, start_o issues.
- Reset asserted after 7 samples: outputs go to 0 asynchronously; after release, a full frame writes bank 0 from ptr 0 with no stale start_o.

Source files
------------

// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - ping-pong stage-0 write front end of the pipelined FFT
// Streams samples into alternating banks and hands full banks to the first-stage reader.
module fft_input_loader #(
  parameter int bit_width = 29,
  parameter int N         = 16,
  parameter int SIZE      = 4,
  parameter int BITREV    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [bit_width-1:0] s_re,
  input  logic [bit_width-1:0] s_im,
  input  logic                 s_last,
  output logic                 en_wr,
  output logic                 wr_bank,
  output logic [SIZE-1:0]      wr_ptr,
  output logic [bit_width-1:0] wr_re,
  output logic [bit_width-1:0] wr_im,
  output logic                 start_o,
  output logic                 start_bank,
  input  logic                 done_i,
  output logic                 err_frame,
  output logic                 busy_o
);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_BUSY} bank_st_t;

  bank_st_t        st [2];
  bank_st_t        st_nx [2];
  logic            fill_bank, fill_nx;
  logic [SIZE-1:0] idx, idx_nx;
  logic            start_bank_q;
  logic            acc, at_end, close, still_busy, both_full, sel, ready_nx;

  function automatic logic [SIZE-1:0] bitrev(input logic [SIZE-1:0] a);
    for (int i = 0; i < SIZE; i++) bitrev[i] = a[SIZE-1-i];
  endfunction

  assign acc        = s_valid && s_ready;
  assign at_end     = (idx == SIZE'(N-1));
  assign close      = acc && (s_last || at_end);
  assign busy_o     = (st[0] == B_BUSY) || (st[1] == B_BUSY);
  // A release in this cycle frees the reader, so a waiting bank may start alongside it.
  assign still_busy = busy_o && !done_i;
  assign both_full  = (st[0] == B_FULL) && (st[1] == B_FULL);
  assign sel        = both_full ? fill_bank : (st[1] == B_FULL);
  assign start_o    = ((st[0] == B_FULL) || (st[1] == B_FULL)) && !still_busy;
  assign start_bank = start_o ? sel : start_bank_q;

  always_comb begin
    st_nx[0] = st[0];
    st_nx[1] = st[1];
    for (int b = 0; b < 2; b++) begin
      if (done_i && st[b] == B_BUSY) st_nx[b] = B_FREE;
      if (start_o && sel == 1'(b)) st_nx[b] = B_BUSY;
      if (acc && fill_bank == 1'(b)) st_nx[b] = close ? B_FULL : B_FILLING;
    end
    fill_nx  = close ? ~fill_bank : fill_bank;
    idx_nx   = close ? '0 : (acc ? idx + 1'b1 : idx);
    ready_nx = (st_nx[fill_nx] == B_FREE) || (st_nx[fill_nx] == B_FILLING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st[0]        <= B_FREE;
      st[1]        <= B_FREE;
      fill_bank    <= 1'b0;
      idx          <= '0;
      s_ready      <= 1'b0;
      start_bank_q <= 1'b0;
      en_wr        <= 1'b0;
      wr_bank      <= 1'b0;
      wr_ptr       <= '0;
      wr_re        <= '0;
      wr_im        <= '0;
      err_frame    <= 1'b0;
    end else begin
      st[0]        <= st_nx[0];
      st[1]        <= st_nx[1];
      fill_bank    <= fill_nx;
      idx          <= idx_nx;
      s_ready      <= ready_nx;
      start_bank_q <= start_bank;
      en_wr        <= acc;
      wr_bank      <= fill_bank;
      wr_ptr       <= (BITREV != 0) ? bitrev(idx) : idx;
      wr_re        <= s_re;
      wr_im        <= s_im;
      err_frame    <= close && (s_last != at_end);
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// tb/tb_fft_input_loader.sv - self-checking bench for fft_input_loader
// Table-driven first frame, directed corner sequences and a randomized run against a bank-queue model.
module tb_fft_input_loader;
  localparam int W = 29;
  localparam int N = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         s_valid = 1'b0, s_last = 1'b0, done_i = 1'b0;
  logic [W-1:0] s_re = '0, s_im = '0;
  logic         s_ready, en_wr, wr_bank, start_o, start_bank, err_frame, busy_o;
  logic [S-1:0] wr_ptr;
  logic [W-1:0] wr_re, wr_im;
  logic         r_s_ready, r_en_wr, r_wr_bank, r_start_o, r_start_bank, r_err_frame, r_busy_o;
  logic [S-1:0] r_wr_ptr;
  logic [W-1:0] r_wr_re, r_wr_im;

  fft_input_loader #(.bit_width(W), .N(N), .SIZE(S), .BITREV(0)) u_nat (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .s_last(s_last), .en_wr(en_wr), .wr_bank(wr_bank), .wr_ptr(wr_ptr), .wr_re(wr_re),
    .wr_im(wr_im), .start_o(start_o), .start_bank(start_bank), .done_i(done_i),
    .err_frame(err_frame), .busy_o(busy_o));

  fft_input_loader #(.bit_width(W), .N(N), .SIZE(S), .BITREV(1)) u_rev (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(r_s_ready), .s_re(s_re), .s_im(s_im),
    .s_last(s_last), .en_wr(r_en_wr), .wr_bank(r_wr_bank), .wr_ptr(r_wr_ptr), .wr_re(r_wr_re),
    .wr_im(r_wr_im), .start_o(r_start_o), .start_bank(r_start_bank), .done_i(done_i),
    .err_frame(r_err_frame), .busy_o(r_busy_o));

  int checks = 0;
  int passed = 0;
  int rtab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  // Model: frames waiting for the reader in arrival order, plus the reader's current bank.
  int           full_q [$];
  int           busy_b, m_fill, m_cnt, last_sb, e_bank, e_ptr;
  int           m_ready, e_en, e_err;
  logic [W-1:0] e_re, e_im;

  typedef struct {
    bit v, last, done;
    int e_en, e_ptr, e_rptr, e_start, e_err;
  } vec_t;
  vec_t tbl [18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    full_q.delete();
    busy_b = -1; m_fill = 0; m_cnt = 0; m_ready = 0; last_sb = 0;
    e_en = 0; e_err = 0; e_bank = 0; e_ptr = 0; e_re = '0; e_im = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit last, input bit done,
                       input logic [W-1:0] re, input logic [W-1:0] im, output bit acc);
    bit rel, st, cl;
    int sb;
    s_valid = v; s_last = last; done_i = done; s_re = re; s_im = im;
    #1;
    rel = done && (busy_b >= 0);
    st  = (full_q.size() > 0) && (busy_b < 0 || rel);
    sb  = st ? full_q[0] : last_sb;
    chk("s_ready", int'(s_ready), m_ready);
    chk("en_wr", int'(en_wr), e_en);
    chk("rev_en_wr", int'(r_en_wr), e_en);
    if (e_en != 0) begin
      chk("wr_bank", int'(wr_bank), e_bank);
      chk("wr_ptr", int'(wr_ptr), e_ptr);
      chk("rev_wr_ptr", int'(r_wr_ptr), rtab[e_ptr]);
      chk("wr_re", int'(wr_re), int'(e_re));
      chk("wr_im", int'(wr_im), int'(e_im));
    end
    chk("start_o", int'(start_o), int'(st));
    chk("start_bank", int'(start_bank), sb);
    chk("err_frame", int'(err_frame), e_err);
    chk("busy_o", int'(busy_o), int'(busy_b >= 0));
    acc = v && (m_ready != 0);
    if (rel) busy_b = -1;
    if (st) begin
      busy_b  = full_q.pop_front();
      last_sb = sb;
    end
    e_en = int'(acc); e_bank = m_fill; e_ptr = m_cnt; e_re = re; e_im = im;
    cl    = acc && (last || m_cnt == N-1);
    e_err = int'(cl && (last != (m_cnt == N-1)));
    if (acc) begin
      if (cl) begin
        full_q.push_back(m_fill);
        m_fill = 1 - m_fill;
        m_cnt  = 0;
      end else m_cnt++;
    end
    m_ready = int'(busy_b != m_fill);
    foreach (full_q[i]) if (full_q[i] == m_fill) m_ready = 0;
  endtask

  task automatic idle(input int n, input bit done);
    bit a;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, done, '0, '0, a);
      tick();
    end
  endtask

  task automatic send_frame(input int n, input int last_at);
    bit a;
    int k = 0;
    int guard = 0;
    while (k < n && guard < 200) begin
      drive(1'b1, (k + 1) == last_at, 1'b0, W'($urandom), W'($urandom), a);
      tick();
      if (a) k++;
      guard++;
    end
    if (k != n) chk("send_timeout", k, n);
  endtask

  initial begin
    bit a;
    model_reset();
    for (int i = 0; i < 18; i++) begin
      tbl[i].v       = (i < 16);
      tbl[i].last    = (i == 15);
      tbl[i].done    = 1'b0;
      tbl[i].e_en    = int'(i >= 1 && i <= 16);
      tbl[i].e_ptr   = (i >= 1 && i <= 16) ? i - 1 : 0;
      tbl[i].e_rptr  = rtab[tbl[i].e_ptr];
      tbl[i].e_start = int'(i == 16);
      tbl[i].e_err   = 0;
    end

    tick(); tick();
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_start_o", int'(start_o), 0);
    chk("rst_busy_o", int'(busy_o), 0);
    rst_n = 1'b1;
    idle(1, 1'b0);

    // First frame with value = index, checked against the literal table.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].last, tbl[i].done, W'(i), W'(3 * i), a);
      chk("tbl_en", int'(en_wr), tbl[i].e_en);
      if (tbl[i].e_en != 0) begin
        chk("tbl_ptr", int'(wr_ptr), tbl[i].e_ptr);
        chk("tbl_rptr", int'(r_wr_ptr), tbl[i].e_rptr);
        chk("tbl_data", int'(wr_re), tbl[i].e_ptr);
        chk("tbl_bank", int'(wr_bank), 0);
      end
      chk("tbl_start", int'(start_o), tbl[i].e_start);
      if (tbl[i].e_start != 0) chk("tbl_start_bank", int'(start_bank), 0);
      chk("tbl_err", int'(err_frame), tbl[i].e_err);
      tick();
    end

    // Second frame fills bank 1 while bank 0 is held; the loader then stalls.
    send_frame(16, 16);
    drive(1'b1, 1'b0, 1'b0, '0, '0, a);
    chk("bp_ready", int'(s_ready), 0);
    tick();
    drive(1'b0, 1'b0, 1'b1, '0, '0, a);
    chk("done_start", int'(start_o), 1);
    chk("done_start_bank", int'(start_bank), 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, a);
    chk("ready_back", int'(s_ready), 1);
    tick();
    send_frame(16, 16);
    idle(2, 1'b1);
    idle(2, 1'b0);

    // Short frame, then a frame missing its s_last.
    send_frame(10, 10);
    drive(1'b0, 1'b0, 1'b0, '0, '0, a);
    chk("short_err", int'(err_frame), 1);
    chk("short_start", int'(start_o), 1);
    tick();
    idle(1, 1'b1);
    send_frame(16, 0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, a);
    chk("nolast_err", int'(err_frame), 1);
    chk("nolast_start", int'(start_o), 1);
    tick();
    idle(2, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
            W'($urandom), W'($urandom), a);
      tick();
    end
    idle(2, 1'b1);
    idle(1, 1'b0);

    // Reset in the middle of a frame.
    send_frame(7, 0);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en_wr", int'(en_wr), 0);
    chk("arst_s_ready", int'(s_ready), 0);
    chk("arst_wr_ptr", int'(wr_ptr), 0);
    chk("arst_busy", int'(busy_o), 0);
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    idle(2, 1'b0);
    send_frame(16, 16);
    drive(1'b0, 1'b0, 1'b0, '0, '0, a);
    chk("post_rst_start", int'(start_o), 1);
    chk("post_rst_bank", int'(start_bank), 0);
    tick();
    idle(3, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
